// File: rtl/elastic_config_loader.sv
// rtl/elastic_config_loader.sv - streams host configuration entries into PE context slots, then starts execution
module elastic_config_loader #(
    parameter int DATA_WIDTH              = 32,
    parameter int CONTEXT_SIZE            = 8,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int NEIGHBOR_PE_NUM         = 4,
    parameter int OPERATION_BIT_LENGTH    = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_request,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_input_PE_index_1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_input_PE_index_2,
    input  logic [NEIGHBOR_PE_NUM-1:0]         in_output_PE_index,
    input  logic [OPERATION_BIT_LENGTH-1:0]    in_op,
    input  logic [DATA_WIDTH-1:0]              in_const_data,
    input  logic                               in_last,
    input  logic                               valid_input,
    output logic                               stop_input,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic                               write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               start_exec,
    output logic                               busy,
    output logic                               exec_active,
    output logic                               config_overflow
);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, RUN} state_t;

    localparam logic [CONTEXT_SIZE_BIT_LENGTH-1:0] LAST_INDEX =
        CONTEXT_SIZE_BIT_LENGTH'(CONTEXT_SIZE - 1);

    state_t                             state;
    state_t                             state_next;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] entry_cnt;
    logic                               accept;
    logic                               final_entry;
    logic                               start_load;

    assign accept      = (state == LOAD) && valid_input;
    // The last context slot ends the load even without in_last, so the counter never wraps.
    assign final_entry = in_last || (entry_cnt == LAST_INDEX);
    assign start_load  = ((state == IDLE) || (state == RUN)) && load_request;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        stop_input  = 1'b1;
        busy        = 1'b0;
        exec_active = 1'b0;
        start_exec  = 1'b0;
        case (state)
            IDLE: begin
                if (load_request) state_next = LOAD;
            end
            LOAD: begin
                stop_input = 1'b0;
                busy       = 1'b1;
                if (accept && final_entry) state_next = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = START;
            end
            START: begin
                busy       = 1'b1;
                start_exec = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                exec_active = 1'b1;
                if (load_request) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_cnt               <= '0;
            config_input_PE_index_1 <= '0;
            config_input_PE_index_2 <= '0;
            config_output_PE_index  <= '0;
            config_op               <= '0;
            config_const_data       <= '0;
            config_index            <= '0;
            write_config_data       <= 1'b0;
            mapping_context_max_id  <= '0;
            config_overflow         <= 1'b0;
        end else begin
            write_config_data <= accept;
            if (start_load) begin
                entry_cnt       <= '0;
                config_overflow <= 1'b0;
            end
            if (accept) begin
                config_input_PE_index_1 <= in_input_PE_index_1;
                config_input_PE_index_2 <= in_input_PE_index_2;
                config_output_PE_index  <= in_output_PE_index;
                config_op               <= in_op;
                config_const_data       <= in_const_data;
                config_index            <= entry_cnt;
                if (final_entry) begin
                    mapping_context_max_id <= entry_cnt;
                    config_overflow        <= ~in_last;
                end else begin
                    entry_cnt <= entry_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_elastic_config_loader.sv
// tb/tb_elastic_config_loader.sv - randomized scoreboard bench for elastic_config_loader
module tb_elastic_config_loader;

    localparam int CS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_request = 1'b0;
    logic [2:0]  in_input_PE_index_1 = '0;
    logic [2:0]  in_input_PE_index_2 = '0;
    logic [3:0]  in_output_PE_index = '0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_const_data = '0;
    logic        in_last = 1'b0;
    logic        valid_input = 1'b0;
    logic        stop_input;
    logic [2:0]  config_input_PE_index_1;
    logic [2:0]  config_input_PE_index_2;
    logic [3:0]  config_output_PE_index;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic        write_config_data;
    logic [2:0]  config_index;
    logic [2:0]  mapping_context_max_id;
    logic        start_exec;
    logic        busy;
    logic        exec_active;
    logic        config_overflow;

    elastic_config_loader dut (
        .clk                     (clk),
        .reset                   (reset),
        .load_request            (load_request),
        .in_input_PE_index_1     (in_input_PE_index_1),
        .in_input_PE_index_2     (in_input_PE_index_2),
        .in_output_PE_index      (in_output_PE_index),
        .in_op                   (in_op),
        .in_const_data           (in_const_data),
        .in_last                 (in_last),
        .valid_input             (valid_input),
        .stop_input              (stop_input),
        .config_input_PE_index_1 (config_input_PE_index_1),
        .config_input_PE_index_2 (config_input_PE_index_2),
        .config_output_PE_index  (config_output_PE_index),
        .config_op               (config_op),
        .config_const_data       (config_const_data),
        .write_config_data       (write_config_data),
        .config_index            (config_index),
        .mapping_context_max_id  (mapping_context_max_id),
        .start_exec              (start_exec),
        .busy                    (busy),
        .exec_active             (exec_active),
        .config_overflow         (config_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  idx;
        logic [2:0]  m1;
        logic [2:0]  m2;
        logic [3:0]  mask;
        logic [3:0]  op;
        logic [31:0] cd;
    } ent_t;

    ent_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: a load is "open" between an honoured request and its final entry;
    // the final entry's cycle number anchors flush/start/run timing.
    int   cyc = 0;
    bit   m_loading = 0;
    bit   m_done = 0;
    bit   m_ovf = 0;
    int   m_n = 0;
    int   m_max = 0;
    int   m_last = -10;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_loading = 0;
            m_done    = 0;
            m_ovf     = 0;
            m_n       = 0;
            m_max     = 0;
            m_last    = -10;
        end else if (m_loading) begin
            if (valid_input) begin
                sb.push_back(ent_t'{3'(m_n), in_input_PE_index_1, in_input_PE_index_2,
                                    in_output_PE_index, in_op, in_const_data});
                if (in_last || m_n == CS - 1) begin
                    m_max     = m_n;
                    m_ovf     = !in_last;
                    m_loading = 0;
                    m_done    = 1;
                    m_last    = cyc;
                end else begin
                    m_n++;
                end
            end
        end else if (load_request && cyc > m_last + 2) begin
            m_loading = 1;
            m_done    = 0;
            m_ovf     = 0;
            m_n       = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_write", 64'(write_config_data), 64'd0);
            chk("rst_cfg", 64'({config_index, config_op, config_const_data, config_output_PE_index,
                                config_input_PE_index_1, config_input_PE_index_2}), 64'd0);
            chk("rst_status", 64'({start_exec, busy, exec_active, config_overflow, mapping_context_max_id}), 64'd0);
            chk("rst_stop", 64'(stop_input), 64'd1);
        end else begin
            chk("write", 64'(write_config_data), 64'(sb.size() != 0));
            if (write_config_data && sb.size() != 0) begin
                ent_t e;
                e = sb.pop_front();
                chk("wr_index", 64'(config_index), 64'(e.idx));
                chk("wr_entry", 64'({config_index, config_input_PE_index_1, config_input_PE_index_2,
                                     config_output_PE_index, config_op, config_const_data}), 64'(e));
            end
            chk("start_exec", 64'(start_exec), 64'(m_done && cyc == m_last + 1));
            chk("busy", 64'(busy), 64'(m_loading || (m_done && (cyc == m_last || cyc == m_last + 1))));
            chk("exec_active", 64'(exec_active), 64'(m_done && !m_loading && cyc >= m_last + 2));
            chk("stop_input", 64'(stop_input), 64'(!m_loading));
            chk("overflow", 64'(config_overflow), 64'(m_ovf));
            chk("max_id", 64'(mapping_context_max_id), 64'(m_max));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back with op=1,2,3..; 1: random gaps; 2: valid pattern 1,0,0,1,1
    task automatic load_seq(input int n, input bit fin_last, input int mode, input int abort_after);
        int acc;
        int step;
        bit v;
        bit pat [5];
        pat = '{1, 0, 0, 1, 1};
        acc = 0;
        step = 0;
        load_request = 1'b1;
        tick();
        load_request = 1'b0;
        chk("ld_overflow_clr", 64'(config_overflow), 64'd0);
        chk("ld_busy", 64'(busy), 64'd1);
        while (acc < n) begin
            v = (mode == 0) ? 1'b1 : (mode == 2) ? pat[step % 5] : ($urandom_range(0, 2) != 0);
            step++;
            valid_input         = v;
            in_op               = (mode == 0) ? 4'(acc + 1) : 4'($urandom);
            in_const_data       = $urandom;
            in_input_PE_index_1 = 3'($urandom);
            in_input_PE_index_2 = 3'($urandom);
            in_output_PE_index  = 4'($urandom);
            in_last             = fin_last && (acc == n - 1);
            if (abort_after >= 0 && acc == abort_after) begin
                valid_input = 1'b0;
                break;
            end
            tick();
            if (v) acc++;
        end
        valid_input = 1'b0;
        in_last     = 1'b0;
    endtask

    // Requests and entries offered during FLUSH/START must be ignored.
    task automatic tail();
        load_request = 1'b1;
        valid_input  = 1'b1;
        tick();
        tick();
        load_request = 1'b0;
        valid_input  = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_stop", 64'(stop_input), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        load_seq(3, 1, 0, -1);
        tail();
        chk("s33_max", 64'(mapping_context_max_id), 64'd2);
        chk("s33_run", 64'(exec_active), 64'd1);

        load_seq(3, 1, 2, -1);
        tail();
        chk("s34_max", 64'(mapping_context_max_id), 64'd2);

        load_seq(CS, 0, 1, -1);
        tail();
        chk("s35_max", 64'(mapping_context_max_id), 64'd7);
        chk("s35_ovf", 64'(config_overflow), 64'd1);

        load_seq(1, 1, 0, -1);
        tail();
        chk("s36_max", 64'(mapping_context_max_id), 64'd0);
        chk("s38_ovf", 64'(config_overflow), 64'd0);

        load_seq(4, 1, 1, 2);
        tick();
        #1 reset = 1'b1;
        #1;
        chk("s37_async_write", 64'(write_config_data), 64'd0);
        chk("s37_async_status", 64'({busy, exec_active, start_exec, config_index}), 64'd0);
        chk("s37_async_stop", 64'(stop_input), 64'd1);
        chk("s37_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        load_seq(2, 1, 0, -1);
        tail();

        for (int i = 0; i < 30; i++) begin
            int  n;
            bit  fl;
            fl = ($urandom_range(0, 3) != 0);
            n  = fl ? $urandom_range(1, CS) : CS;
            load_seq(n, fl, 1, -1);
            tail();
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
